// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: widths, invalid address code and FSM state encoding.
// Consumers import router_pkg::* so the FSM and datapath agree on encodings.
`default_nettype none

package router_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_BITS  = 2;

    localparam logic [DEF_ADDR_BITS-1:0] INVALID_ADDR = 2'b11;

    typedef enum logic [2:0] {
        ST_DECODE_ADDRESS     = 3'd0,
        ST_LOAD_FIRST_DATA    = 3'd1,
        ST_LOAD_DATA          = 3'd2,
        ST_FIFO_FULL_STATE    = 3'd3,
        ST_LOAD_AFTER_FULL    = 3'd4,
        ST_LOAD_PARITY        = 3'd5,
        ST_CHECK_PARITY_ERROR = 3'd6,
        ST_WAIT_TILL_EMPTY    = 3'd7
    } router_state_e;

    function automatic logic addr_is_valid(input logic [DEF_ADDR_BITS-1:0] addr);
        return addr != INVALID_ADDR;
    endfunction

endpackage

`default_nettype wire

// File: rtl/router_reg_if.sv
// Bus between the router FSM/source (master) and the router_reg datapath (slave).
// With ROUTER_REG_ERR_CNT_EN defined the bus also carries err_count.
`default_nettype none

interface router_reg_if
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  pkt_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  fifo_full;
    logic                  detect_add;
    logic                  lfd_state;
    logic                  ld_state;
    logic                  full_state;
    logic                  laf_state;
    logic                  rst_int_reg;
    logic                  parity_done;
    logic                  low_pkt_valid;
    logic                  err;
    logic [DATA_WIDTH-1:0] dout;

`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0]            err_count;

    modport master (
        output pkt_valid, data_in, fifo_full, detect_add, lfd_state,
               ld_state, full_state, laf_state, rst_int_reg,
        input  parity_done, low_pkt_valid, err, dout, err_count
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, detect_add, lfd_state,
               ld_state, full_state, laf_state, rst_int_reg,
        output parity_done, low_pkt_valid, err, dout, err_count
    );
`else
    modport master (
        output pkt_valid, data_in, fifo_full, detect_add, lfd_state,
               ld_state, full_state, laf_state, rst_int_reg,
        input  parity_done, low_pkt_valid, err, dout
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, detect_add, lfd_state,
               ld_state, full_state, laf_state, rst_int_reg,
        output parity_done, low_pkt_valid, err, dout
    );
`endif

endinterface

`default_nettype wire

// File: rtl/router_parity_acc.sv
// Running XOR parity, packet parity capture and the parity error flag for router_reg.
// Optional saturating mismatch counter when ROUTER_REG_ERR_CNT_EN is defined.
`default_nettype none

module router_parity_acc
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  detect_add_i,
    input  logic                  lfd_state_i,
    input  logic                  ld_state_i,
    input  logic                  pkt_valid_i,
    input  logic                  rst_int_reg_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic [DATA_WIDTH-1:0] header_i,
`ifdef ROUTER_REG_ERR_CNT_EN
    output logic [7:0]            err_count_o,
`endif
    output logic                  err_o
);

    logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
    logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
    logic                  err_q, err_d;
    logic                  mismatch;

    assign mismatch = (int_parity_q != pkt_parity_q);

    always_comb begin
        int_parity_d = int_parity_q;
        pkt_parity_d = pkt_parity_q;
        err_d        = err_q;

        if (detect_add_i)
            int_parity_d = '0;
        else if (lfd_state_i)
            int_parity_d = int_parity_q ^ header_i;
        else if (ld_state_i && pkt_valid_i)
            int_parity_d = int_parity_q ^ data_in_i;

        // The parity byte is captured even when it is diverted to the hold register.
        if (ld_state_i && !pkt_valid_i)
            pkt_parity_d = data_in_i;

        if (rst_int_reg_i)
            err_d = mismatch;
        else if (lfd_state_i)
            err_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            int_parity_q <= '0;
            pkt_parity_q <= '0;
            err_q        <= 1'b0;
        end else begin
            int_parity_q <= int_parity_d;
            pkt_parity_q <= pkt_parity_d;
            err_q        <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (rst_int_reg_i && mismatch && (err_count_q != 8'hFF))
            err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            err_count_q <= 8'h00;
        else
            err_count_q <= err_count_d;
    end

    assign err_count_o = err_count_q;
`endif

endmodule

`default_nettype wire

// File: rtl/router_reg.sv
// Router datapath register stage: header/hold/dout registers plus parity_done and low_pkt_valid flags.
// Define ROUTER_REG_ERR_CNT_EN to add the err_count output on the bus.
`default_nettype none

module router_reg
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
    input  logic         clock,
    input  logic         resetn,
    router_reg_if.slave  bus
);

    localparam logic [ADDR_BITS-1:0] INVALID_ADDR_W = ADDR_BITS'(INVALID_ADDR);

    logic [DATA_WIDTH-1:0] header_q, header_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  parity_done_q, parity_done_d;
    logic                  low_pkt_valid_q, low_pkt_valid_d;
    logic                  addr_ok;
    logic                  unused_full_state;

    // The FSM already blocks data while full, so the full decode needs no action here.
    assign unused_full_state = bus.full_state;

    assign addr_ok = (bus.data_in[ADDR_BITS-1:0] != INVALID_ADDR_W);

    always_comb begin
        header_d        = header_q;
        hold_d          = hold_q;
        dout_d          = dout_q;
        parity_done_d   = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;

        if (bus.detect_add && bus.pkt_valid && addr_ok)
            header_d = bus.data_in;

        if (bus.lfd_state)
            dout_d = header_q;
        else if (bus.ld_state && !bus.fifo_full)
            dout_d = bus.data_in;
        else if (bus.ld_state && bus.fifo_full)
            hold_d = bus.data_in;
        else if (bus.laf_state)
            dout_d = hold_q;

        if (bus.ld_state && !bus.pkt_valid)
            low_pkt_valid_d = 1'b1;
        else if (bus.rst_int_reg)
            low_pkt_valid_d = 1'b0;

        if (bus.detect_add)
            parity_done_d = 1'b0;
        else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                 (bus.laf_state && low_pkt_valid_q && !parity_done_q))
            parity_done_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            header_q        <= '0;
            hold_q          <= '0;
            dout_q          <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
        end else begin
            header_q        <= header_d;
            hold_q          <= hold_d;
            dout_q          <= dout_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
        end
    end

    router_parity_acc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_acc (
        .clock         (clock),
        .resetn        (resetn),
        .detect_add_i  (bus.detect_add),
        .lfd_state_i   (bus.lfd_state),
        .ld_state_i    (bus.ld_state),
        .pkt_valid_i   (bus.pkt_valid),
        .rst_int_reg_i (bus.rst_int_reg),
        .data_in_i     (bus.data_in),
        .header_i      (header_q),
`ifdef ROUTER_REG_ERR_CNT_EN
        .err_count_o   (bus.err_count),
`endif
        .err_o         (bus.err)
    );

    assign bus.dout          = dout_q;
    assign bus.parity_done   = parity_done_q;
    assign bus.low_pkt_valid = low_pkt_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_router_reg.sv
// Directed self-checking bench for router_reg; FSM decodes are driven by hand each cycle.
`default_nettype none

module tb_router_reg;

    logic clock;
    logic resetn;
    int   n_cmp;
    int   n_bad;

    router_reg_if #(.DATA_WIDTH(8)) bus ();

    router_reg #(.DATA_WIDTH(8), .ADDR_BITS(2)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of decodes/source inputs, then sample 1 ns after the edge.
    task automatic cyc(input logic da, input logic lfd, input logic ld, input logic full,
                       input logic laf, input logic rir, input logic pv, input logic ff,
                       input logic [7:0] d);
        bus.detect_add  = da;
        bus.lfd_state   = lfd;
        bus.ld_state    = ld;
        bus.full_state  = full;
        bus.laf_state   = laf;
        bus.rst_int_reg = rir;
        bus.pkt_valid   = pv;
        bus.fifo_full   = ff;
        bus.data_in     = d;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] got;
        resetn = 1'b0;
        cyc(0,0,0,0,0,0,0,0,8'h5A);
        cyc(0,0,0,0,0,0,0,0,8'h5A);
        got = {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err};
        n_cmp++;
        if (got !== {8'h00, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_state got=%h want=%h", got, {8'h00, 3'b000});
        end
        resetn = 1'b1;
    endtask

    task automatic test_normal();
        logic [10:0] got;
        cyc(1,0,0,0,0,0,1,0,8'h05);
        cyc(0,1,0,0,0,0,1,0,8'h11);
        n_cmp++;
        if (bus.dout !== 8'h05) begin
            n_bad++; $display("FAIL normal_hdr dout=%h want=05", bus.dout);
        end
        cyc(0,0,1,0,0,0,1,0,8'h11);
        cyc(0,0,1,0,0,0,1,0,8'h22);
        got = {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err};
        n_cmp++;
        if (got !== {8'h22, 3'b000}) begin
            n_bad++; $display("FAIL normal_payload got=%h want=%h", got, {8'h22, 3'b000});
        end
        cyc(0,0,1,0,0,0,0,0,8'h36);
        got = {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err};
        n_cmp++;
        if (got !== {8'h36, 3'b110}) begin
            n_bad++; $display("FAIL normal_parity got=%h want=%h", got, {8'h36, 3'b110});
        end
        cyc(0,0,0,0,0,1,0,0,8'h00);
        got = {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err};
        n_cmp++;
        if (got !== {8'h36, 3'b100}) begin
            n_bad++; $display("FAIL normal_check got=%h want=%h", got, {8'h36, 3'b100});
        end
    endtask

    task automatic test_bad_parity();
        logic [10:0] got;
        cyc(1,0,0,0,0,0,1,0,8'h05);
        cyc(0,1,0,0,0,0,1,0,8'h11);
        cyc(0,0,1,0,0,0,1,0,8'h11);
        cyc(0,0,1,0,0,0,1,0,8'h22);
        cyc(0,0,1,0,0,0,0,0,8'h37);
        cyc(0,0,0,0,0,1,0,0,8'h00);
        got = {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err};
        n_cmp++;
        if (got !== {8'h37, 3'b101}) begin
            n_bad++; $display("FAIL bad_check got=%h want=%h", got, {8'h37, 3'b101});
        end
        cyc(0,0,0,0,0,0,0,0,8'h00);
        cyc(0,0,0,0,0,0,0,0,8'h00);
        n_cmp++;
        if (bus.err !== 1'b1) begin
            n_bad++; $display("FAIL bad_idle_hold err=%b want=1", bus.err);
        end
        cyc(1,0,0,0,0,0,1,0,8'h05);
        got = {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err};
        n_cmp++;
        if (got !== {8'h37, 3'b001}) begin
            n_bad++; $display("FAIL b2b_detect got=%h want=%h", got, {8'h37, 3'b001});
        end
        cyc(0,1,0,0,0,0,1,0,8'h11);
        got = {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err};
        n_cmp++;
        if (got !== {8'h05, 3'b000}) begin
            n_bad++; $display("FAIL bad_lfd_clear got=%h want=%h", got, {8'h05, 3'b000});
        end
    endtask

    task automatic test_full_payload();
        logic [10:0] got;
        cyc(1,0,0,0,0,0,1,0,8'h05);
        cyc(0,1,0,0,0,0,1,0,8'h11);
        cyc(0,0,1,0,0,0,1,0,8'h11);
        cyc(0,0,1,0,0,0,1,1,8'hAA);
        n_cmp++;
        if (bus.dout !== 8'h11) begin
            n_bad++; $display("FAIL fullpay_hold dout=%h want=11", bus.dout);
        end
        cyc(0,0,0,1,0,0,1,1,8'h22);
        n_cmp++;
        if (bus.dout !== 8'h11) begin
            n_bad++; $display("FAIL fullpay_fullst dout=%h want=11", bus.dout);
        end
        cyc(0,0,0,0,1,0,1,0,8'h22);
        got = {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err};
        n_cmp++;
        if (got !== {8'hAA, 3'b000}) begin
            n_bad++; $display("FAIL fullpay_laf got=%h want=%h", got, {8'hAA, 3'b000});
        end
        cyc(0,0,1,0,0,0,1,0,8'h22);
        cyc(0,0,1,0,0,0,0,0,8'h9C);
        cyc(0,0,0,0,0,1,0,0,8'h00);
        got = {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err};
        n_cmp++;
        if (got !== {8'h9C, 3'b100}) begin
            n_bad++; $display("FAIL fullpay_parity got=%h want=%h", got, {8'h9C, 3'b100});
        end
    endtask

    task automatic test_full_parity();
        logic [10:0] got;
        cyc(1,0,0,0,0,0,1,0,8'h05);
        cyc(0,1,0,0,0,0,1,0,8'h11);
        cyc(0,0,1,0,0,0,1,0,8'h11);
        cyc(0,0,1,0,0,0,1,0,8'h22);
        cyc(0,0,1,0,0,0,0,1,8'h36);
        got = {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err};
        n_cmp++;
        if (got !== {8'h22, 3'b010}) begin
            n_bad++; $display("FAIL fullpar_ld got=%h want=%h", got, {8'h22, 3'b010});
        end
        cyc(0,0,0,1,0,0,0,1,8'h00);
        got = {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err};
        n_cmp++;
        if (got !== {8'h22, 3'b010}) begin
            n_bad++; $display("FAIL fullpar_fullst got=%h want=%h", got, {8'h22, 3'b010});
        end
        cyc(0,0,0,0,1,0,0,0,8'h00);
        got = {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err};
        n_cmp++;
        if (got !== {8'h36, 3'b110}) begin
            n_bad++; $display("FAIL fullpar_laf got=%h want=%h", got, {8'h36, 3'b110});
        end
        cyc(0,0,0,0,0,1,0,0,8'h00);
        got = {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err};
        n_cmp++;
        if (got !== {8'h36, 3'b100}) begin
            n_bad++; $display("FAIL fullpar_check got=%h want=%h", got, {8'h36, 3'b100});
        end
    endtask

    task automatic test_invalid_addr();
        cyc(1,0,0,0,0,0,1,0,8'h09);
        cyc(0,1,0,0,0,0,1,0,8'h55);
        n_cmp++;
        if (bus.dout !== 8'h09) begin
            n_bad++; $display("FAIL addr_valid_hdr dout=%h want=09", bus.dout);
        end
        cyc(0,0,1,0,0,0,1,0,8'h55);
        cyc(1,0,0,0,0,0,1,0,8'h03);
        cyc(0,1,0,0,0,0,1,0,8'h55);
        n_cmp++;
        if (bus.dout !== 8'h09) begin
            n_bad++; $display("FAIL addr_invalid dout=%h want=09", bus.dout);
        end
        cyc(0,0,1,0,0,0,1,0,8'h55);
        cyc(1,0,0,0,0,0,0,0,8'h0A);
        cyc(0,1,0,0,0,0,0,0,8'h55);
        n_cmp++;
        if (bus.dout !== 8'h09) begin
            n_bad++; $display("FAIL addr_no_valid dout=%h want=09", bus.dout);
        end
        cyc(1,0,0,0,0,0,1,0,8'h0A);
        cyc(0,1,0,0,0,0,1,0,8'h55);
        n_cmp++;
        if (bus.dout !== 8'h0A) begin
            n_bad++; $display("FAIL addr_new_hdr dout=%h want=0A", bus.dout);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] got;
        cyc(1,0,0,0,0,0,1,0,8'h05);
        cyc(0,1,0,0,0,0,1,0,8'h11);
        cyc(0,0,1,0,0,0,1,0,8'h11);
        cyc(0,0,1,0,0,0,1,0,8'h22);
        cyc(0,0,1,0,0,0,0,0,8'h37);
        cyc(0,0,0,0,0,1,0,0,8'h00);
        cyc(1,0,0,0,0,0,1,0,8'h06);
        resetn = 1'b0;
        cyc(0,0,1,0,0,0,0,0,8'h77);
        resetn = 1'b1;
        got = {bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err};
        n_cmp++;
        if (got !== {8'h00, 3'b000}) begin
            n_bad++; $display("FAIL reset_mid got=%h want=%h", got, {8'h00, 3'b000});
        end
        cyc(0,1,0,0,0,0,1,0,8'h11);
        n_cmp++;
        if (bus.dout !== 8'h00) begin
            n_bad++; $display("FAIL reset_mid_hdr dout=%h want=00", bus.dout);
        end
    endtask

`ifdef ROUTER_REG_ERR_CNT_EN
    task automatic run_packet(input logic [7:0] par);
        cyc(1,0,0,0,0,0,1,0,8'h05);
        cyc(0,1,0,0,0,0,1,0,8'h11);
        cyc(0,0,1,0,0,0,1,0,8'h11);
        cyc(0,0,1,0,0,0,1,0,8'h22);
        cyc(0,0,1,0,0,0,0,0,par);
        cyc(0,0,0,0,0,1,0,0,8'h00);
    endtask

    task automatic test_err_count();
        resetn = 1'b0;
        cyc(0,0,0,0,0,0,0,0,8'h00);
        resetn = 1'b1;
        run_packet(8'h37);
        run_packet(8'h36);
        run_packet(8'h00);
        run_packet(8'hFF);
        n_cmp++;
        if (bus.err_count !== 8'd3) begin
            n_bad++; $display("FAIL err_count got=%0d want=3", bus.err_count);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        resetn = 1'b0;
        test_reset();
        test_normal();
        test_bad_parity();
        test_full_payload();
        test_full_parity();
        test_invalid_addr();
        test_reset_mid();
`ifdef ROUTER_REG_ERR_CNT_EN
        test_err_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
